// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - prioritised edge-captured interrupt controller with a memory-mapped register window
module irq_controller #(
  parameter int          NSRC      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h40000020
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic            rd,
  input  logic            wr,
  output logic [31:0]     rdata,
  input  logic            pc_kernel,
  input  logic            irq_taken,
  output logic            irq,
  output logic [2:0]      irq_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [NSRC-1:0] pend, pend_n;
  logic [NSRC-1:0] mask;
  logic            en;
  logic [NSRC-1:0] src_d;
  logic            irq_n;
  logic [2:0]      irq_id_n;

  logic            hit;
  logic [1:0]      off;
  logic            wr_pend, wr_mask, wr_eoi, wr_ctrl;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] taken_clr;
  logic [NSRC-1:0] sel;
  logic [NSRC-1:0] ready;
  logic            sel_active;

  assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
  assign off     = addr[3:2];
  assign wr_pend = wr && hit && (off == 2'd0);
  assign wr_mask = wr && hit && (off == 2'd1);
  assign wr_eoi  = wr && hit && (off == 2'd2);
  assign wr_ctrl = wr && hit && (off == 2'd3);

  assign rise  = src & ~src_d;
  assign w1c   = wr_pend ? wdata[NSRC-1:0] : '0;
  assign ready = pend & mask;

  // One-hot decode of irq_id keeps the bit selects within NSRC for any legal width.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (irq_id == i[2:0]) sel[i] = 1'b1;
    end
  end

  assign sel_active = (|(sel & ready)) && en;

  always_comb begin
    state_n   = state;
    irq_n     = irq;
    irq_id_n  = irq_id;
    taken_clr = '0;
    case (state)
      IDLE: begin
        irq_n = 1'b0;
        if (en && !pc_kernel && (|ready)) begin
          for (int i = NSRC - 1; i >= 0; i--) begin
            if (ready[i]) irq_id_n = i[2:0];
          end
          irq_n   = 1'b1;
          state_n = ASSERT;
        end
      end
      ASSERT: begin
        if (irq_taken) begin
          taken_clr = sel;
          irq_n     = 1'b0;
          state_n   = SERVICE;
        end else if (!sel_active) begin
          irq_n   = 1'b0;
          state_n = IDLE;
        end
      end
      SERVICE: begin
        irq_n = 1'b0;
        if (wr_eoi) state_n = IDLE;
      end
      default: begin
        irq_n   = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // A fresh edge always wins over a software or acknowledge clear in the same cycle.
  assign pend_n = rise | (pend & ~w1c & ~taken_clr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pend   <= '0;
      mask   <= '0;
      en     <= 1'b0;
      src_d  <= '0;
      irq    <= 1'b0;
      irq_id <= 3'd0;
    end else begin
      state  <= state_n;
      pend   <= pend_n;
      src_d  <= src;
      irq    <= irq_n;
      irq_id <= irq_id_n;
      if (wr_mask) mask <= wdata[NSRC-1:0];
      if (wr_ctrl) en <= wdata[0];
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (rd && hit) begin
      case (off)
        2'd0: rdata[NSRC-1:0] = pend;
        2'd1: rdata[NSRC-1:0] = mask;
        2'd2: rdata = {(state == SERVICE), 28'd0, irq_id};
        default: rdata[0] = en;
      endcase
    end
  end

endmodule
